// File: rtl/axil_reg_slice.sv
// AXI4-Lite register slice: each of the five channels is independently bypass, forward register or skid buffer.
// Define AXIL_SLICE_ZERO_IDLE_EN to force registered payload outputs to zero while their valid is low.

module axil_slice_fwd #(
  parameter int W = 32
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
`ifdef AXIL_SLICE_ZERO_IDLE_EN
      out_data  <= in_valid ? in_data : '0;
`else
      if (in_valid) out_data <= in_data;
`endif
    end
  end

endmodule

// state    | meaning
// ST_EMPTY | nothing held, out_valid low
// ST_FULL  | one beat in the out register, skid register empty
// ST_SKID  | beats in out and skid registers, in_ready low
module axil_slice_skid #(
  parameter int W = 32
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [W-1:0] out_data_nxt;
  logic [W-1:0] skid_data, skid_data_nxt;
  logic         in_ready_q;
  logic         accept, drain;

  assign in_ready = in_ready_q;
  assign accept   = in_valid && in_ready_q;
  assign drain    = out_valid && out_ready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= ST_EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_data  <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      out_valid  <= (state_nxt != ST_EMPTY);
      out_data   <= out_data_nxt;
      skid_data  <= skid_data_nxt;
      in_ready_q <= (state_nxt != ST_SKID);
    end
  end

  always_comb begin
    state_nxt     = state;
    out_data_nxt  = out_data;
    skid_data_nxt = skid_data;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt    = ST_FULL;
          out_data_nxt = in_data;
        end
      end
      ST_FULL: begin
        if (accept && drain) begin
          out_data_nxt = in_data;
        end else if (accept) begin
          state_nxt     = ST_SKID;
          skid_data_nxt = in_data;
        end else if (drain) begin
          state_nxt = ST_EMPTY;
`ifdef AXIL_SLICE_ZERO_IDLE_EN
          out_data_nxt = '0;
`endif
        end
      end
      ST_SKID: begin
        // in_ready is low here, so the only event is the out register draining
        if (drain) begin
          state_nxt    = ST_FULL;
          out_data_nxt = skid_data;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

endmodule

module axil_slice_chan #(
  parameter int W    = 32,
  parameter int MODE = 2
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  generate
    if (MODE == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = aclk ^ aresetn;
      assign out_data  = in_data;
      assign out_valid = in_valid;
      assign in_ready  = out_ready;
    end else if (MODE == 1) begin : g_fwd
      axil_slice_fwd #(.W(W)) u_fwd (
        .aclk(aclk), .aresetn(aresetn),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
      );
    end else begin : g_skid
      axil_slice_skid #(.W(W)) u_skid (
        .aclk(aclk), .aresetn(aresetn),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
      );
    end
  endgenerate

endmodule

module axil_reg_slice #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int AW_MODE    = 2,
  parameter int W_MODE     = 2,
  parameter int B_MODE     = 2,
  parameter int AR_MODE    = 2,
  parameter int R_MODE     = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,

  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam int AX_W = ADDR_WIDTH + 3;
  localparam int WD_W = DATA_WIDTH + STRB_WIDTH;
  localparam int RD_W = DATA_WIDTH + 2;

  logic [AX_W-1:0] aw_out, ar_out;
  logic [WD_W-1:0] w_out;
  logic [RD_W-1:0] r_out;

  assign {m_axil_awaddr, m_axil_awprot} = aw_out;
  assign {m_axil_wdata, m_axil_wstrb}   = w_out;
  assign {m_axil_araddr, m_axil_arprot} = ar_out;
  assign {s_axil_rdata, s_axil_rresp}   = r_out;

  axil_slice_chan #(.W(AX_W), .MODE(AW_MODE)) u_aw (
    .aclk(aclk), .aresetn(aresetn),
    .in_data({s_axil_awaddr, s_axil_awprot}), .in_valid(s_axil_awvalid), .in_ready(s_axil_awready),
    .out_data(aw_out), .out_valid(m_axil_awvalid), .out_ready(m_axil_awready)
  );

  axil_slice_chan #(.W(WD_W), .MODE(W_MODE)) u_w (
    .aclk(aclk), .aresetn(aresetn),
    .in_data({s_axil_wdata, s_axil_wstrb}), .in_valid(s_axil_wvalid), .in_ready(s_axil_wready),
    .out_data(w_out), .out_valid(m_axil_wvalid), .out_ready(m_axil_wready)
  );

  axil_slice_chan #(.W(2), .MODE(B_MODE)) u_b (
    .aclk(aclk), .aresetn(aresetn),
    .in_data(m_axil_bresp), .in_valid(m_axil_bvalid), .in_ready(m_axil_bready),
    .out_data(s_axil_bresp), .out_valid(s_axil_bvalid), .out_ready(s_axil_bready)
  );

  axil_slice_chan #(.W(AX_W), .MODE(AR_MODE)) u_ar (
    .aclk(aclk), .aresetn(aresetn),
    .in_data({s_axil_araddr, s_axil_arprot}), .in_valid(s_axil_arvalid), .in_ready(s_axil_arready),
    .out_data(ar_out), .out_valid(m_axil_arvalid), .out_ready(m_axil_arready)
  );

  axil_slice_chan #(.W(RD_W), .MODE(R_MODE)) u_r (
    .aclk(aclk), .aresetn(aresetn),
    .in_data({m_axil_rdata, m_axil_rresp}), .in_valid(m_axil_rvalid), .in_ready(m_axil_rready),
    .out_data(r_out), .out_valid(s_axil_rvalid), .out_ready(s_axil_rready)
  );

endmodule

// File: tb/tb_axil_reg_slice.sv
// Bench for axil_reg_slice: skid/forward instance checked by an in-order scoreboard, plus an all-bypass instance.
// Expectations for idle payload follow AXIL_SLICE_ZERO_IDLE_EN when it is defined.
module tb_axil_reg_slice;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [31:0] s_awaddr = '0, m_awaddr, s_araddr = '0, m_araddr;
  logic [2:0]  s_awprot = '0, m_awprot, s_arprot = '0, m_arprot;
  logic        s_awvalid = 0, s_awready, m_awvalid, m_awready = 0;
  logic [31:0] s_wdata = '0, m_wdata, s_rdata, m_rdata = '0;
  logic [3:0]  s_wstrb = '0, m_wstrb;
  logic        s_wvalid = 0, s_wready, m_wvalid, m_wready = 0;
  logic [1:0]  s_bresp, m_bresp = '0, s_rresp, m_rresp = '0;
  logic        s_bvalid, s_bready = 0, m_bvalid = 0, m_bready;
  logic        s_arvalid = 0, s_arready, m_arvalid, m_arready = 0;
  logic        s_rvalid, s_rready = 0, m_rvalid = 0, m_rready;

  axil_reg_slice #(.AW_MODE(2), .W_MODE(2), .B_MODE(1), .AR_MODE(2), .R_MODE(1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(s_awaddr), .s_axil_awprot(s_awprot), .s_axil_awvalid(s_awvalid), .s_axil_awready(s_awready),
    .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb), .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready),
    .s_axil_bresp(s_bresp), .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready),
    .s_axil_araddr(s_araddr), .s_axil_arprot(s_arprot), .s_axil_arvalid(s_arvalid), .s_axil_arready(s_arready),
    .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp), .s_axil_rvalid(s_rvalid), .s_axil_rready(s_rready),
    .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
    .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
    .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
    .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
    .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready)
  );

  logic [31:0] p_s_awaddr = '0, p_m_awaddr, p_s_araddr = '0, p_m_araddr;
  logic [2:0]  p_s_awprot = '0, p_m_awprot, p_s_arprot = '0, p_m_arprot;
  logic        p_s_awvalid = 0, p_s_awready, p_m_awvalid, p_m_awready = 0;
  logic [31:0] p_s_wdata = '0, p_m_wdata, p_s_rdata, p_m_rdata = '0;
  logic [3:0]  p_s_wstrb = '0, p_m_wstrb;
  logic        p_s_wvalid = 0, p_s_wready, p_m_wvalid, p_m_wready = 0;
  logic [1:0]  p_s_bresp, p_m_bresp = '0, p_s_rresp, p_m_rresp = '0;
  logic        p_s_bvalid, p_s_bready = 0, p_m_bvalid = 0, p_m_bready;
  logic        p_s_arvalid = 0, p_s_arready, p_m_arvalid, p_m_arready = 0;
  logic        p_s_rvalid, p_s_rready = 0, p_m_rvalid = 0, p_m_rready;

  axil_reg_slice #(.AW_MODE(0), .W_MODE(0), .B_MODE(0), .AR_MODE(0), .R_MODE(0)) dut_byp (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(p_s_awaddr), .s_axil_awprot(p_s_awprot), .s_axil_awvalid(p_s_awvalid), .s_axil_awready(p_s_awready),
    .s_axil_wdata(p_s_wdata), .s_axil_wstrb(p_s_wstrb), .s_axil_wvalid(p_s_wvalid), .s_axil_wready(p_s_wready),
    .s_axil_bresp(p_s_bresp), .s_axil_bvalid(p_s_bvalid), .s_axil_bready(p_s_bready),
    .s_axil_araddr(p_s_araddr), .s_axil_arprot(p_s_arprot), .s_axil_arvalid(p_s_arvalid), .s_axil_arready(p_s_arready),
    .s_axil_rdata(p_s_rdata), .s_axil_rresp(p_s_rresp), .s_axil_rvalid(p_s_rvalid), .s_axil_rready(p_s_rready),
    .m_axil_awaddr(p_m_awaddr), .m_axil_awprot(p_m_awprot), .m_axil_awvalid(p_m_awvalid), .m_axil_awready(p_m_awready),
    .m_axil_wdata(p_m_wdata), .m_axil_wstrb(p_m_wstrb), .m_axil_wvalid(p_m_wvalid), .m_axil_wready(p_m_wready),
    .m_axil_bresp(p_m_bresp), .m_axil_bvalid(p_m_bvalid), .m_axil_bready(p_m_bready),
    .m_axil_araddr(p_m_araddr), .m_axil_arprot(p_m_arprot), .m_axil_arvalid(p_m_arvalid), .m_axil_arready(p_m_arready),
    .m_axil_rdata(p_m_rdata), .m_axil_rresp(p_m_rresp), .m_axil_rvalid(p_m_rvalid), .m_axil_rready(p_m_rready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Channel views: 0=AW 1=W 2=B 3=AR 4=R; "in" is the source side, "out" the sink side
  logic [63:0] ipay[5], opay[5];
  logic        iv[5], irdy[5], ov[5], ordy[5];
  always_comb begin
    ipay[0] = {29'd0, s_awprot, s_awaddr};  opay[0] = {29'd0, m_awprot, m_awaddr};
    ipay[1] = {28'd0, s_wstrb, s_wdata};    opay[1] = {28'd0, m_wstrb, m_wdata};
    ipay[2] = {62'd0, m_bresp};             opay[2] = {62'd0, s_bresp};
    ipay[3] = {29'd0, s_arprot, s_araddr};  opay[3] = {29'd0, m_arprot, m_araddr};
    ipay[4] = {30'd0, m_rresp, m_rdata};    opay[4] = {30'd0, s_rresp, s_rdata};
    iv[0] = s_awvalid; irdy[0] = s_awready; ov[0] = m_awvalid; ordy[0] = m_awready;
    iv[1] = s_wvalid;  irdy[1] = s_wready;  ov[1] = m_wvalid;  ordy[1] = m_wready;
    iv[2] = m_bvalid;  irdy[2] = m_bready;  ov[2] = s_bvalid;  ordy[2] = s_bready;
    iv[3] = s_arvalid; irdy[3] = s_arready; ov[3] = m_arvalid; ordy[3] = m_arready;
    iv[4] = m_rvalid;  irdy[4] = m_rready;  ov[4] = s_rvalid;  ordy[4] = s_rready;
  end

  // Reference model: each channel is an in-order FIFO of accepted beats; reset discards everything held
  logic [63:0] sb[5][$];
  string cname[5] = '{"aw", "w", "b", "ar", "r"};

  initial forever begin
    @(negedge aclk); #3;
    for (int c = 0; c < 5; c++) begin
      if (!aresetn) sb[c].delete();
      else if (iv[c] && irdy[c]) sb[c].push_back(ipay[c]);
    end
  end

  logic        stall_prev[5];
  logic [63:0] pay_prev[5];
  initial begin
    for (int c = 0; c < 5; c++) begin stall_prev[c] = 1'b0; pay_prev[c] = '0; end
    forever begin
      @(negedge aclk); #4;
      for (int c = 0; c < 5; c++) begin
        if (!aresetn) stall_prev[c] = 1'b0;
        else begin
          if (stall_prev[c]) check({cname[c], "_hold"}, 128'({ov[c], opay[c]}), 128'({1'b1, pay_prev[c]}));
          if (ov[c] && ordy[c]) begin
            if (sb[c].size() == 0) begin
              checks++; errors++;
              $display("FAIL %s_order: got beat %0h expected no beat", cname[c], opay[c]);
            end else check({cname[c], "_beat"}, 128'(opay[c]), 128'(sb[c].pop_front()));
          end
          stall_prev[c] = ov[c] && !ordy[c];
          pay_prev[c] = opay[c];
        end
      end
    end
  end

  logic acc[5];
  task automatic rand_cycle(input int pv, input int pr);
    @(negedge aclk);
    if (!s_awvalid || acc[0]) begin
      s_awvalid = ($urandom_range(99) < 32'(pv)); s_awaddr = $urandom; s_awprot = 3'($urandom);
    end
    if (!s_wvalid || acc[1]) begin
      s_wvalid = ($urandom_range(99) < 32'(pv)); s_wdata = $urandom; s_wstrb = 4'($urandom);
    end
    if (!m_bvalid || acc[2]) begin
      m_bvalid = ($urandom_range(99) < 32'(pv)); m_bresp = 2'($urandom);
    end
    if (!s_arvalid || acc[3]) begin
      s_arvalid = ($urandom_range(99) < 32'(pv)); s_araddr = $urandom; s_arprot = 3'($urandom);
    end
    if (!m_rvalid || acc[4]) begin
      m_rvalid = ($urandom_range(99) < 32'(pv)); m_rdata = $urandom; m_rresp = 2'($urandom);
    end
    m_awready = ($urandom_range(99) < 32'(pr));
    m_wready  = ($urandom_range(99) < 32'(pr));
    s_bready  = ($urandom_range(99) < 32'(pr));
    m_arready = ($urandom_range(99) < 32'(pr));
    s_rready  = ($urandom_range(99) < 32'(pr));
    #4;
    for (int c = 0; c < 5; c++) acc[c] = iv[c] && irdy[c];
  endtask

  logic [1:0] bresp_idle;
  int idx, recv;

  initial begin
`ifdef AXIL_SLICE_ZERO_IDLE_EN
    bresp_idle = 2'd0;
`else
    bresp_idle = 2'd2;
`endif
    for (int c = 0; c < 5; c++) acc[c] = 1'b0;

    // reset state
    repeat (2) @(negedge aclk);
    #4;
    check("rst_valid", 128'({m_awvalid, m_wvalid, s_bvalid, m_arvalid, s_rvalid}), 128'(0));
    check("rst_payload", 128'({m_awaddr, m_wdata, s_bresp, m_araddr, s_rdata, s_rresp}), 128'(0));
    check("rst_ready", 128'({s_awready, s_wready, s_arready}), 128'(0));
    @(negedge aclk); aresetn = 1'b1;
    @(negedge aclk); #4;
    check("rel_ready", 128'({s_awready, s_wready, s_arready}), 128'(3'b111));

    // AW back-to-back with sink always ready
    m_awready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge aclk);
      s_awvalid = (i < 8); s_awaddr = 32'(i * 4); s_awprot = 3'd0;
      #4;
      if (i < 8) check("aw_ready", 128'(s_awready), 128'(1));
      if (i >= 1) check("aw_stream", 128'({m_awvalid, m_awaddr}), 128'({1'b1, 32'((i - 1) * 4)}));
    end

    // W skid: stall sink, offer D0 then D1
    m_wready = 1'b0;
    @(negedge aclk); s_wvalid = 1'b1; s_wdata = 32'h1111_0000; s_wstrb = 4'hF; #4;
    check("w_rdy0", 128'(s_wready), 128'(1));
    @(negedge aclk); s_wdata = 32'h2222_0001; #4;
    check("w_rdy1", 128'(s_wready), 128'(1));
    check("w_out0", 128'({m_wvalid, m_wdata}), 128'({1'b1, 32'h1111_0000}));
    @(negedge aclk); s_wvalid = 1'b0; #4;
    check("w_skid_rdy", 128'(s_wready), 128'(0));
    check("w_out_hold", 128'({m_wvalid, m_wdata}), 128'({1'b1, 32'h1111_0000}));
    @(negedge aclk); m_wready = 1'b1; #4;
    check("w_drain0", 128'({m_wvalid, m_wdata}), 128'({1'b1, 32'h1111_0000}));
    @(negedge aclk); #4;
    check("w_drain1", 128'({m_wvalid, m_wdata}), 128'({1'b1, 32'h2222_0001}));
    check("w_rdy_back", 128'(s_wready), 128'(1));
    @(negedge aclk); #4;
    check("w_empty", 128'(m_wvalid), 128'(0));

    // R forward register with upstream ready toggling
    idx = 0; recv = 0;
    for (int cyc = 0; cyc < 200 && recv < 16; cyc++) begin
      @(negedge aclk);
      s_rready = (cyc % 2 == 0);
      m_rvalid = (idx < 16); m_rdata = 32'hA5A5_0000 + 32'(idx); m_rresp = 2'd0;
      #4;
      if (m_rvalid && m_rready) idx++;
      if (s_rvalid && s_rready) begin
        check("r_seq", 128'(s_rdata), 128'(32'hA5A5_0000 + 32'(recv)));
        recv++;
      end
    end
    check("r_count", 128'(recv), 128'(16));
    @(negedge aclk); m_rvalid = 1'b0; s_rready = 1'b0;

    // B SLVERR then idle payload
    @(negedge aclk); m_bvalid = 1'b1; m_bresp = 2'd2; s_bready = 1'b1; #4;
    @(negedge aclk); m_bvalid = 1'b0; #4;
    check("b_beat", 128'({s_bvalid, s_bresp}), 128'({1'b1, 2'd2}));
    @(negedge aclk); #4;
    check("b_idle", 128'({s_bvalid, s_bresp}), 128'({1'b0, bresp_idle}));

    // AR fills skid, then a one-cycle reset drops both beats
    m_arready = 1'b0;
    @(negedge aclk); s_arvalid = 1'b1; s_araddr = 32'hA000_0000; s_arprot = 3'd1; #4;
    check("ar_rdy0", 128'(s_arready), 128'(1));
    @(negedge aclk); s_araddr = 32'hA000_0004; #4;
    @(negedge aclk); s_araddr = 32'hA000_0008; #4;
    check("ar_skid_rdy", 128'(s_arready), 128'(0));
    @(negedge aclk); aresetn = 1'b0; #4;
    @(negedge aclk); aresetn = 1'b1; s_arvalid = 1'b0; m_arready = 1'b1; #4;
    check("rst2_valid", 128'({m_awvalid, m_wvalid, s_bvalid, m_arvalid, s_rvalid}), 128'(0));
    check("rst2_ar", 128'({s_arready, m_araddr, m_arprot}), 128'(0));
    @(negedge aclk); #4;
    check("rst2_rdy", 128'(s_arready), 128'(1));
    repeat (3) begin
      @(negedge aclk); #4;
      check("ar_dropped", 128'(m_arvalid), 128'(0));
    end

    // randomized traffic, then drain
    @(negedge aclk);
    s_awvalid = 0; s_wvalid = 0; m_bvalid = 0; s_arvalid = 0; m_rvalid = 0;
    for (int c = 0; c < 5; c++) acc[c] = 1'b0;
    repeat (1500) rand_cycle(60, 70);
    repeat (500) rand_cycle(90, 30);
    repeat (40) rand_cycle(0, 100);
    for (int c = 0; c < 5; c++) begin
      check({cname[c], "_drained"}, 128'({ov[c], 32'(sb[c].size())}), 128'(0));
    end

    // bypass instance: combinational pass-through in both directions
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      p_s_awaddr = $urandom; p_s_awprot = 3'($urandom); p_s_awvalid = 1'($urandom);
      p_s_wdata = $urandom; p_s_wstrb = 4'($urandom); p_s_wvalid = 1'($urandom);
      p_s_araddr = $urandom; p_s_arprot = 3'($urandom); p_s_arvalid = 1'($urandom);
      p_m_bresp = 2'($urandom); p_m_bvalid = 1'($urandom);
      p_m_rdata = $urandom; p_m_rresp = 2'($urandom); p_m_rvalid = 1'($urandom);
      p_m_awready = 1'($urandom); p_m_wready = 1'($urandom); p_m_arready = 1'($urandom);
      p_s_bready = 1'($urandom); p_s_rready = 1'($urandom);
      #4;
      check("byp_fwd",
        128'({p_m_awaddr, p_m_awprot, p_m_awvalid, p_m_wdata, p_m_wstrb, p_m_wvalid, p_m_araddr, p_m_arprot, p_m_arvalid}),
        128'({p_s_awaddr, p_s_awprot, p_s_awvalid, p_s_wdata, p_s_wstrb, p_s_wvalid, p_s_araddr, p_s_arprot, p_s_arvalid}));
      check("byp_rev",
        128'({p_s_bresp, p_s_bvalid, p_s_rdata, p_s_rresp, p_s_rvalid}),
        128'({p_m_bresp, p_m_bvalid, p_m_rdata, p_m_rresp, p_m_rvalid}));
      check("byp_ready",
        128'({p_s_awready, p_s_wready, p_s_arready, p_m_bready, p_m_rready}),
        128'({p_m_awready, p_m_wready, p_m_arready, p_s_bready, p_s_rready}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
